// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Bundle of the fetch stage's control, branch-resolution,
//               instruction-memory and F/D-latch signals.
//   master : fetch unit side (drives imem_addr and the F/D outputs)
//   slave  : environment side (hazard unit, execute stage, imem)
//   Signals: stall, redirect, redirect_pc, upd_en, upd_pc, upd_taken,
//            upd_target, imem_addr, imem_data, tg_out, pc_out,
//            pc_plus1_out, ir_out, fd_en, fd_flush
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] tg_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus1_out;
  logic [31:0] ir_out;
  logic        fd_en;
  logic        fd_flush;

  modport master (
    input  stall, redirect, redirect_pc,
    input  upd_en, upd_pc, upd_taken, upd_target,
    input  imem_data,
    output imem_addr, tg_out, pc_out, pc_plus1_out, ir_out, fd_en, fd_flush
  );

  modport slave (
    output stall, redirect, redirect_pc,
    output upd_en, upd_pc, upd_taken, upd_target,
    output imem_data,
    input  imem_addr, tg_out, pc_out, pc_plus1_out, ir_out, fd_en, fd_flush
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Holds the PC, drives instruction
//               memory, and predicts the next PC with an optional
//               direct-mapped branch target buffer (2-bit counters).
//   clk  : clock, rising edge
//   clr  : synchronous active-low reset
//   bus  : fetch_unit_if.master (control, branch update, imem, F/D outputs)
// Parameters  : RESET_PC    - PC after reset
//               BTB_ENTRIES - BTB depth, power of two, 2..256
// Macro       : FETCH_BTB_EN - when defined, the BTB is built; otherwise the
//               predicted target is always PC+1 and updates are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic         clk,
  input  logic         clr,
  fetch_unit_if.master bus
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus1;
  logic [31:0] w_tg;

  assign w_pc_plus1       = r_pc + 32'd1;
  assign bus.imem_addr    = r_pc;
  assign bus.pc_out       = r_pc;
  assign bus.pc_plus1_out = w_pc_plus1;
  assign bus.ir_out       = bus.imem_data;
  assign bus.tg_out       = w_tg;
  // A redirect must reach the latch (as a flush) even while stalled.
  assign bus.fd_en        = ~bus.stall | bus.redirect;
  assign bus.fd_flush     = bus.redirect;

  always_ff @(posedge clk) begin
    if (!clr) begin
      r_pc <= RESET_PC;
    end else if (bus.redirect) begin
      r_pc <= bus.redirect_pc;
    end else if (!bus.stall) begin
      r_pc <= w_tg;
    end
  end

`ifdef FETCH_BTB_EN
  localparam int c_idx_w = $clog2(BTB_ENTRIES);
  localparam int c_tag_w = 32 - c_idx_w;

  logic               r_valid  [BTB_ENTRIES];
  logic [c_tag_w-1:0] r_tag    [BTB_ENTRIES];
  logic [31:0]        r_target [BTB_ENTRIES];
  logic [1:0]         r_cnt    [BTB_ENTRIES];

  logic [c_idx_w-1:0] w_idx;
  logic [c_idx_w-1:0] w_upd_idx;
  logic               w_hit;
  logic               w_upd_hit;

  assign w_idx     = r_pc[c_idx_w-1:0];
  assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == r_pc[31:c_idx_w]);
  // Lookup reads the registered arrays, so a same-cycle update to the
  // same index only becomes visible after the edge.
  assign w_tg      = (w_hit && r_cnt[w_idx][1]) ? r_target[w_idx] : w_pc_plus1;

  assign w_upd_idx = bus.upd_pc[c_idx_w-1:0];
  assign w_upd_hit = r_valid[w_upd_idx] &&
                     (r_tag[w_upd_idx] == bus.upd_pc[31:c_idx_w]);

  // Tags and targets are not reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_cnt[i]   <= 2'b01;
      end
    end else if (bus.upd_en) begin
      if (w_upd_hit) begin
        if (bus.upd_taken) begin
          if (r_cnt[w_upd_idx] != 2'b11) begin
            r_cnt[w_upd_idx] <= r_cnt[w_upd_idx] + 2'b01;
          end
          r_target[w_upd_idx] <= bus.upd_target;
        end else if (r_cnt[w_upd_idx] != 2'b00) begin
          r_cnt[w_upd_idx] <= r_cnt[w_upd_idx] - 2'b01;
        end
      end else if (bus.upd_taken) begin
        // Miss on a taken branch allocates as weakly taken.
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= bus.upd_pc[31:c_idx_w];
        r_target[w_upd_idx] <= bus.upd_target;
        r_cnt[w_upd_idx]    <= 2'b10;
      end
    end
  end
`else
  assign w_tg = w_pc_plus1;

  wire w_unused = ^{bus.upd_en, bus.upd_pc, bus.upd_taken, bus.upd_target,
                    (BTB_ENTRIES == 0)};
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit (RESET_PC=0x100,
//               16-entry BTB). Expectations follow the build's FETCH_BTB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
  localparam logic [31:0] c_reset_pc = 32'h0000_0100;
  localparam logic [31:0] c_ir_key   = 32'hA5A5_0000;
`ifdef FETCH_BTB_EN
  localparam bit c_btb = 1'b1;
`else
  localparam bit c_btb = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr;
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(c_reset_pc), .BTB_ENTRIES(16)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory model: word derived from its address.
  assign bus.imem_data = bus.imem_addr ^ c_ir_key;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic jump(input logic [31:0] pc);
    bus.redirect    = 1'b1;
    bus.redirect_pc = pc;
    cyc();
    bus.redirect    = 1'b0;
    settle();
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    bus.upd_en     = 1'b1;
    bus.upd_pc     = pc;
    bus.upd_taken  = taken;
    bus.upd_target = tgt;
    cyc();
    bus.upd_en     = 1'b0;
  endtask

  initial begin
    clr             = 1'b0;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.upd_en      = 1'b0;
    bus.upd_pc      = 32'h0;
    bus.upd_taken   = 1'b0;
    bus.upd_target  = 32'h0;
    repeat (2) cyc();
    clr = 1'b1;
    settle();

    // First cycle after reset
    check("rst_addr",  bus.imem_addr, 32'h100);
    check("rst_tg",    bus.tg_out, 32'h101);
    check("rst_flush", {31'b0, bus.fd_flush}, 32'h0);
    check("rst_fden",  {31'b0, bus.fd_en}, 32'h1);
    check("rst_ir",    bus.ir_out, 32'hA5A5_0100);

    // Sequential fetch
    for (int i = 1; i < 4; i++) begin
      cyc();
      check("seq_addr", bus.imem_addr, 32'h100 + 32'(i));
      check("seq_tg",   bus.tg_out, 32'h101 + 32'(i));
    end

    // Stall holds PC and instruction
    jump(32'h05);
    check("jmp5_addr", bus.imem_addr, 32'h05);
    bus.stall = 1'b1;
    settle();
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_addr", bus.imem_addr, 32'h05);
      check("stall_pc",   bus.pc_out, 32'h05);
      check("stall_ir",   bus.ir_out, 32'hA5A5_0005);
      check("stall_fden", {31'b0, bus.fd_en}, 32'h0);
    end

    // Redirect beats stall
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    settle();
    check("rs_flush", {31'b0, bus.fd_flush}, 32'h1);
    check("rs_fden",  {31'b0, bus.fd_en}, 32'h1);
    cyc();
    bus.redirect = 1'b0;
    bus.stall    = 1'b0;
    settle();
    check("rs_addr", bus.imem_addr, 32'h40);

    // Allocate taken branch at 0x12 -> 0x80
    upd(32'h12, 1'b1, 32'h80);
    jump(32'h12);
    check("alloc_tg", bus.tg_out, c_btb ? 32'h80 : 32'h13);
    cyc();
    check("alloc_next", bus.imem_addr, c_btb ? 32'h80 : 32'h13);

    // Two not-taken updates: 10 -> 01 -> 00
    upd(32'h12, 1'b0, 32'h0);
    upd(32'h12, 1'b0, 32'h0);
    jump(32'h12);
    check("nt2_tg", bus.tg_out, 32'h13);

    // Four taken (00 -> 11, saturating), new target 0x90
    for (int i = 0; i < 4; i++) upd(32'h12, 1'b1, 32'h90);
    jump(32'h12);
    bus.stall = 1'b1;
    settle();
    check("sat_tg", bus.tg_out, c_btb ? 32'h90 : 32'h13);
    // Not-taken update on the index being looked up: old value this cycle
    bus.upd_en    = 1'b1;
    bus.upd_pc    = 32'h12;
    bus.upd_taken = 1'b0;
    settle();
    check("same_cyc_tg", bus.tg_out, c_btb ? 32'h90 : 32'h13);
    cyc();
    check("nt1_tg", bus.tg_out, c_btb ? 32'h90 : 32'h13);
    cyc();
    bus.upd_en = 1'b0;
    settle();
    check("nt2b_tg", bus.tg_out, 32'h13);
    bus.stall = 1'b0;

    // PC wrap
    jump(32'hFFFF_FFFF);
    check("wrap_p1", bus.pc_plus1_out, 32'h0);
    check("wrap_tg", bus.tg_out, 32'h0);
    cyc();
    check("wrap_addr", bus.imem_addr, 32'h0);

    // Reset overrides redirect, stall and a BTB allocation
    clr             = 1'b0;
    bus.stall       = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h55;
    bus.upd_en      = 1'b1;
    bus.upd_pc      = 32'h100;
    bus.upd_taken   = 1'b1;
    bus.upd_target  = 32'h200;
    cyc();
    clr          = 1'b1;
    bus.stall    = 1'b0;
    bus.redirect = 1'b0;
    bus.upd_en   = 1'b0;
    settle();
    check("rst2_addr",  bus.imem_addr, 32'h100);
    check("rst2_tg",    bus.tg_out, 32'h101);
    check("rst2_flush", {31'b0, bus.fd_flush}, 32'h0);
    jump(32'h12);
    check("rst2_btb_clr", bus.tg_out, 32'h13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter BTB_ENTRIES, default 16: number of BTB entries; SHALL be a power of two, 2..256.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 clr  input  1  reset; synchronous, active-low; sampled on rising clk edge.
REQ-005 stall  input  1  hazard-unit hold; 1 = PC and outputs frozen.
REQ-006 redirect  input  1  execute-stage mispredict; 1 = load redirect_pc.
REQ-007 redirect_pc  input  32  corrected fetch address.
REQ-008 upd_en  input  1  execute-stage branch resolution valid.
REQ-009 upd_pc  input  32  PC of the resolved branch.
REQ-010 upd_taken  input  1  resolved direction.
REQ-011 upd_target  input  32  resolved taken target.
REQ-012 imem_addr  output  32  instruction memory address (= current PC).
REQ-013 imem_data  input  32  instruction word for imem_addr, valid in the same cycle.
REQ-014 tg_out, pc_out, pc_plus1_out, ir_out  output  32 each  taken-guess, PC, PC+1, instruction toward the F/D latch.
REQ-015 fd_en  output  1  F/D latch enable (= ~stall | redirect).
REQ-016 fd_flush  output  1  F/D latch clear (= redirect).

Function
REQ-017 pc_out = imem_addr = PC register; ir_out = imem_data; pc_plus1_out = PC+1 modulo 2^32 (32'hFFFF_FFFF wraps to 0).
REQ-018 BTB entry: valid bit, tag = PC[31:log2(BTB_ENTRIES)], 32-bit target, 2-bit saturating counter; index = PC[log2(BTB_ENTRIES)-1:0].
REQ-019 hit = indexed entry valid AND tag match; tg_out = BTB target when hit AND counter[1]=1, else pc_plus1_out.
REQ-020 Next PC priority per edge: redirect -> redirect_pc; else stall -> hold PC; else tg_out.
REQ-021 redirect asserted with stall: redirect wins; fd_flush=1 and fd_en=1 that cycle.
REQ-022 upd_en with upd_pc hit: counter +1 if upd_taken (saturate at 11), -1 if not (saturate at 00); target <= upd_target when upd_taken.
REQ-023 upd_en with upd_pc miss: upd_taken=1 allocates/overwrites entry (valid=1, tag, target, counter=10); upd_taken=0 leaves BTB unchanged.
REQ-024 BTB updates are independent of stall and redirect.
REQ-025 Same-cycle update and lookup of one index: lookup returns the pre-update contents; the update is visible from the next cycle.
REQ-026 Fetch latency: PC change visible on imem_addr one cycle after the deciding edge; lookup and output path combinational from PC and imem_data.

Reset
REQ-027 clr=0 at a rising edge: PC <= RESET_PC, all BTB valid <= 0, all counters <= 01; targets and tags don't-care.
REQ-028 Reset SHALL override redirect, stall and upd_en in the same cycle.
REQ-029 First cycle after reset: imem_addr=RESET_PC, tg_out=RESET_PC+1, fd_flush=0, fd_en=1 if stall=0.
REQ-030 Reset mid-stall or mid-redirect discards the pending action; no BTB write occurs.

Configuration
REQ-031 Macro FETCH_BTB_EN defined: BTB, REQ-018..REQ-025 prediction and update behaviour present.
REQ-032 FETCH_BTB_EN undefined: no BTB storage; tg_out = pc_plus1_out always; upd_* ignored; all other requirements unchanged.

Verification
REQ-033 Reset with RESET_PC=0x100, stall=0 for 4 cycles -> imem_addr 0x100,0x101,0x102,0x103; tg_out = PC+1 each cycle.
REQ-034 PC=0x05, stall=1 for 3 cycles -> imem_addr, pc_out, ir_out held at 0x05 / same word; fd_en=0.
REQ-035 stall=1 and redirect=1 with redirect_pc=0x40 -> fd_flush=1, fd_en=1; next cycle imem_addr=0x40.
REQ-036 (FETCH_BTB_EN) upd_en, upd_pc=0x12, upd_taken=1, upd_target=0x80; later fetch of 0x12 -> tg_out=0x80, next PC 0x80; two not-taken updates -> tg_out=0x13.
REQ-037 Counter saturation: four taken updates to 0x12 then one not-taken -> still predicts taken (counter 10); a second not-taken -> predicts 0x13.
REQ-038 PC=0xFFFF_FFFF, BTB miss -> pc_plus1_out=0, next imem_addr=0; without FETCH_BTB_EN repeat REQ-036 stimulus -> tg_out always PC+1.
